// File: rtl/load_store_unit.sv
// Load/store unit: the only master of a single-cycle registered memory.
// It serves one core request at a time, either a load or a store.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, LWAIT, RESP} state_t;

    state_t      state, state_next;
    logic        accept;
    logic        req_fault;
    logic [31:0] st_wdata;
    logic [3:0]  st_mask;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        lat_we;
    logic [1:0]  lat_off;
    logic [2:0]  lat_funct3;

    assign accept = req_valid & req_ready;

    // Misaligned halfwords/words, reserved width codes and unsigned stores all fault.
    always_comb begin
        req_fault = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: req_fault = 1'b0;
            3'b001, 3'b101: req_fault = req_addr[0];
            3'b010:         req_fault = |req_addr[1:0];
            default:        req_fault = 1'b1;
        endcase
        if (req_we && (req_funct3 >= 3'b011))
            req_fault = 1'b1;
    end

    always_comb begin
        st_wdata = req_wdata;
        st_mask  = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_mask  = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_mask  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Lane selection and extension of the word returned by memory.
    always_comb begin
        byte_sel  = mem_rdata[8*lat_off +: 8];
        half_sel  = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (lat_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_fault ? RESP : ACCESS;
            ACCESS:  state_next = lat_we ? RESP : LWAIT;
            LWAIT:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
    end

    // Memory strobes are set on the accept edge so they are live only during ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_fault  <= 1'b0;
            mem_addr   <= '0;
            mem_ren    <= 1'b0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 4'h0;
            lat_we     <= 1'b0;
            lat_off    <= 2'b00;
            lat_funct3 <= 3'b000;
        end else begin
            rsp_valid <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wmask <= 4'h0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we     <= req_we;
                        lat_off    <= req_addr[1:0];
                        lat_funct3 <= req_funct3;
                        if (req_fault) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            mem_addr <= req_addr;
                            mem_ren  <= ~req_we;
                            if (req_we) begin
                                mem_wdata <= st_wdata;
                                mem_wmask <= st_mask;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (lat_we) begin
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= 32'h0;
                    end
                end
                LWAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a small registered memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    logic        memInit;
    logic [31:0] mem [0:63];

    int testsRun = 0;
    int testsFailed = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_addr   (mem_addr),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // 64-word memory with one-cycle registered read and byte-masked write.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h8899_AABB;
            mem[63] <= 32'hCAFE_F00D;
            mem_rdata <= 32'h0;
        end else begin
            if (mem_ren) mem_rdata <= mem[mem_addr[7:2]];
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One request from an idle unit; watches at most 8 cycles for the response.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                 input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                                 output logic fault, output logic [3:0] accMask,
                                 output logic [31:0] accWdata, output logic anyRen,
                                 output logic [3:0] anyMask);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 32'h0; fault = 1'b0; accMask = 4'h0; accWdata = 32'h0;
        anyRen = 1'b0; anyMask = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                accMask  = mem_wmask;
                accWdata = mem_wdata;
            end
            anyRen  = anyRen | mem_ren;
            anyMask = anyMask | mem_wmask;
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                fault = rsp_fault;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic [31:0] aw;
    logic        flt;
    logic        ar;
    logic [3:0]  am;
    logic [3:0]  anym;
    logic [6:0]  readyVec;
    logic [6:0]  rspVec;
    int          extraRsp;

    initial begin
        reset = 1'b1; memInit = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_funct3 = 3'b0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        memInit = 1'b0;
        checkOutput("rst_ready", 32'(req_ready), 32'h1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_wmask", 32'(mem_wmask), 32'h0);
        checkOutput("rst_ren", 32'(mem_ren), 32'h0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        reset = 1'b0;

        applyStimulus(1'b0, 32'h13, 3'b000, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lb_data", rd, 32'hFFFF_FF88);
        checkOutput("lb_fault", 32'(flt), 32'h0);
        checkOutput("lb_latency", 32'(lat), 32'd3);
        checkOutput("lb_ren", 32'(ar), 32'h1);

        applyStimulus(1'b0, 32'h13, 3'b100, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lbu_data", rd, 32'h0000_0088);
        applyStimulus(1'b0, 32'h12, 3'b001, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lh_data", rd, 32'hFFFF_8899);
        applyStimulus(1'b0, 32'h10, 3'b101, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lhu_data", rd, 32'h0000_AABB);
        applyStimulus(1'b0, 32'h10, 3'b010, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lw_data", rd, 32'h8899_AABB);
        checkOutput("lw_load_wmask", 32'(anym), 32'h0);

        applyStimulus(1'b1, 32'h21, 3'b000, 32'h5A, lat, rd, flt, am, aw, ar, anym);
        checkOutput("sb_wmask", 32'(am), 32'h2);
        checkOutput("sb_wdata", aw, 32'h5A5A_5A5A);
        checkOutput("sb_latency", 32'(lat), 32'd2);
        checkOutput("sb_ren", 32'(ar), 32'h0);
        checkOutput("sb_rdata", rd, 32'h0);
        applyStimulus(1'b0, 32'h20, 3'b010, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lw_after_sb", rd, 32'h0000_5A00);

        applyStimulus(1'b1, 32'h26, 3'b001, 32'h0000_BEEF, lat, rd, flt, am, aw, ar, anym);
        checkOutput("sh_hi_wmask", 32'(am), 32'hC);
        checkOutput("sh_hi_wdata", aw, 32'hBEEF_BEEF);

        applyStimulus(1'b1, 32'h24, 3'b010, 32'h1234_5678, lat, rd, flt, am, aw, ar, anym);
        checkOutput("sw_wmask", 32'(am), 32'hF);
        checkOutput("sw_latency", 32'(lat), 32'd2);
        applyStimulus(1'b0, 32'h24, 3'b010, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lw_after_sw", rd, 32'h1234_5678);

        applyStimulus(1'b0, 32'hFFFF_FFFC, 3'b010, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("wrap_data", rd, 32'hCAFE_F00D);
        checkOutput("wrap_fault", 32'(flt), 32'h0);

        applyStimulus(1'b0, 32'h22, 3'b010, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("lw_mis_fault", 32'(flt), 32'h1);
        checkOutput("lw_mis_rdata", rd, 32'h0);
        checkOutput("lw_mis_latency", 32'(lat), 32'd1);
        checkOutput("lw_mis_ren", 32'(ar), 32'h0);
        checkOutput("lw_mis_wmask", 32'(anym), 32'h0);

        applyStimulus(1'b1, 32'h31, 3'b001, 32'hFFFF, lat, rd, flt, am, aw, ar, anym);
        checkOutput("sh_mis_fault", 32'(flt), 32'h1);
        checkOutput("sh_mis_latency", 32'(lat), 32'd1);
        checkOutput("sh_mis_wmask", 32'(anym), 32'h0);

        applyStimulus(1'b0, 32'h10, 3'b111, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("ill_fault", 32'(flt), 32'h1);
        checkOutput("ill_rdata", rd, 32'h0);
        checkOutput("ill_latency", 32'(lat), 32'd1);
        checkOutput("ill_ren", 32'(ar), 32'h0);

        applyStimulus(1'b1, 32'h10, 3'b100, 32'h0, lat, rd, flt, am, aw, ar, anym);
        checkOutput("sbu_fault", 32'(flt), 32'h1);

        // Two loads with req_valid held high: second accepted in the single IDLE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            readyVec[k-1] = req_ready;
            rspVec[k-1]   = rsp_valid;
            if (k == 7) req_valid = 1'b0;
        end
        checkOutput("b2b_ready", 32'(readyVec), 32'h08);
        checkOutput("b2b_rsp", 32'(rspVec), 32'h44);
        checkOutput("b2b_rdata", rsp_rdata, 32'h8899_AABB);
        extraRsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) extraRsp++;
        end
        checkOutput("b2b_extra_rsp", 32'(extraRsp), 32'h0);

        // Reset during the ACCESS cycle of a store must cancel the write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_funct3 = 3'b010; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_wmask_before", 32'(mem_wmask), 32'hF);
        reset = 1'b1;
        #1;
        checkOutput("rstmid_wmask_after", 32'(mem_wmask), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rstmid_mem", mem[16], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rstmid_ready", 32'(req_ready), 32'h1);
        extraRsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) extraRsp++;
        end
        checkOutput("rstmid_no_rsp", 32'(extraRsp), 32'h0);
        checkOutput("rstmid_mem_final", mem[16], 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
